m1553_manchester_tx: RTL and testbench
======================================

M1553_MANCHESTER_TX -- requirements
Module: m1553_manchester_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_HALF_BIT, default 25, i_clk cycles per 0.5 us half-bit; legal range >= 2.
REQ-002 SHALL have port i_clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_valid  input  1  word request; accepted when i_valid && o_ready on a rising edge.
REQ-005 SHALL have port i_data  input  16  word payload, transmitted MSB (bit 15) first.
REQ-006 SHALL have port i_sync_type  input  1  1 = command/status sync, 0 = data sync.
REQ-007 SHALL have port o_ready  output  1  able to accept a word this cycle.
REQ-008 SHALL have port o_tx_pos  output  1  bus positive drive level.
REQ-009 SHALL have port o_tx_neg  output  1  bus negative drive level.
REQ-010 SHALL have port o_tx_en  output  1  transceiver driver enable.
REQ-011 SHALL have port o_done  output  1  one-cycle pulse marking the last cycle of a word.

Function
REQ-012 SHALL implement states IDLE, SYNC, DATA, PARITY; one word = 40 half-bits = 40*CLKS_PER_HALF_BIT cycles.
REQ-013 SHALL capture i_data and i_sync_type on acceptance; input changes after acceptance have no effect.
REQ-014 SHALL drive the first sync half-bit on the cycle after acceptance (1-cycle latency); all outputs registered.
REQ-015 SHALL drive the 6 sync half-bits on o_tx_pos as H,H,H,L,L,L when sync_type=1 and L,L,L,H,H,H when 0.
REQ-016 SHALL Manchester-encode each data bit as two half-bits: logic 1 = H then L, logic 0 = L then H.
REQ-017 SHALL append one parity bit = odd parity over the 16 data bits (~^data), encoded per REQ-016.
REQ-018 SHALL hold o_tx_neg = ~o_tx_pos while o_tx_en = 1; both SHALL be 0 while o_tx_en = 0.
REQ-019 SHALL hold o_tx_en = 1 for every cycle of SYNC, DATA and PARITY, 0 in IDLE.
REQ-020 SHALL assert o_ready in IDLE and on the final cycle of the parity bit's second half-bit only; 0 otherwise.
REQ-021 SHALL assert o_done on the final cycle of the parity bit's second half-bit.
REQ-022 SHALL, if a word is accepted on the o_done cycle, start its sync on the next cycle with no gap and o_tx_en staying 1.
REQ-023 SHALL return to IDLE after o_done if no word is accepted, with o_tx_pos/o_tx_neg/o_tx_en = 0 on the next cycle.
REQ-024 SHALL ignore i_valid while o_ready = 0 (no queuing, no corruption of the word in flight).
REQ-025 SHALL size the half-bit counter to $clog2(CLKS_PER_HALF_BIT) bits, wrapping from CLKS_PER_HALF_BIT-1 to 0.

Reset
REQ-026 SHALL, on i_rst assertion, immediately force state IDLE, counters 0, o_tx_pos/o_tx_neg/o_tx_en/o_done = 0.
REQ-027 SHALL present o_ready = 1 (IDLE) once i_rst is released; a word interrupted by reset is discarded, not resumed.

Verification (CLKS_PER_HALF_BIT = 4)
REQ-028 SHALL verify: accept 16'h0000, sync_type=1 -> o_tx_pos per half-bit HHHLLL, 16x(L,H), parity 1 (H,L); o_done 160 cycles after acceptance.
REQ-029 SHALL verify: accept 16'h0001, sync_type=0 -> LLLHHH, 15x(L,H), (H,L), parity 0 (L,H); o_tx_neg = ~o_tx_pos throughout.
REQ-030 SHALL verify: i_valid held high with 16'hFFFF then 16'h5555 -> 320 contiguous cycles of o_tx_en = 1, second sync starts the cycle after first o_done; parities 1 and 1.
REQ-031 SHALL verify: i_rst asserted at half-bit 10 -> all outputs 0 without waiting for a clock edge; after release o_ready = 1, next word transmits correctly.
REQ-032 SHALL verify: i_valid pulsed and i_data changed mid-word -> in-flight word unchanged, extra request ignored, IDLE follows o_done.
REQ-033 SHALL verify: no i_valid for 1000 cycles after reset -> o_tx_pos, o_tx_neg, o_tx_en, o_done constant 0, o_ready constant 1.

Source files
------------

// File: rtl/m1553_manchester_tx.sv
// rtl/m1553_manchester_tx.sv - MIL-STD-1553 word transmitter: sync, Manchester data, odd parity
module m1553_manchester_tx #(
    parameter int CLKS_PER_HALF_BIT = 25
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [15:0] i_data,
    input  logic        i_sync_type,
    output logic        o_ready,
    output logic        o_tx_pos,
    output logic        o_tx_neg,
    output logic        o_tx_en,
    output logic        o_done
);

    localparam int CW = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_HALF_BIT - 1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, PARITY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    hb_q, hb_d;
    logic [15:0]   data_q, data_d;
    logic          sync_q, sync_d;
    logic          par_q, par_d;
    logic          tx_pos_q, tx_pos_d;
    logic          tx_neg_q, tx_neg_d;
    logic          tx_en_q, tx_en_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic          accept;
    logic          start;
    logic          level;

    // Next-state sequencing; outputs are derived from the next state so they are registered
    always_comb begin
        accept   = i_valid && ready_q;
        start    = 1'b0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        hb_d     = hb_q;
        data_d   = data_q;
        sync_d   = sync_q;
        par_d    = par_q;

        if (state_q == IDLE) begin
            start = accept;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
            hb_d  = hb_q + 5'd1;
            case (state_q)
                SYNC: begin
                    if (hb_q == 5'd5) begin
                        state_d = DATA;
                        hb_d    = '0;
                    end
                end
                DATA: begin
                    // Second half of a bit done: move the next bit to the MSB
                    if (hb_q[0]) begin
                        data_d = {data_q[14:0], 1'b0};
                    end
                    if (hb_q == 5'd31) begin
                        state_d = PARITY;
                        hb_d    = '0;
                    end
                end
                PARITY: begin
                    if (hb_q == 5'd1) begin
                        hb_d = '0;
                        if (accept) begin
                            start = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (start) begin
            state_d = SYNC;
            cnt_d   = '0;
            hb_d    = '0;
            data_d  = i_data;
            sync_d  = i_sync_type;
            par_d   = ~^i_data;
        end

        case (state_d)
            SYNC:    level = sync_d ? (hb_d < 5'd3) : (hb_d >= 5'd3);
            DATA:    level = data_d[15] ^ hb_d[0];
            PARITY:  level = par_d ^ hb_d[0];
            default: level = 1'b0;
        endcase

        tx_en_d  = (state_d != IDLE);
        tx_pos_d = tx_en_d & level;
        tx_neg_d = tx_en_d & ~level;
        done_d   = (state_d == PARITY) && (hb_d == 5'd1) && (cnt_d == CNT_MAX);
        ready_d  = (state_d == IDLE) || done_d;
    end

    // State and output registers; reset drops the word in flight immediately
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hb_q     <= '0;
            data_q   <= '0;
            sync_q   <= 1'b0;
            par_q    <= 1'b0;
            tx_pos_q <= 1'b0;
            tx_neg_q <= 1'b0;
            tx_en_q  <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hb_q     <= hb_d;
            data_q   <= data_d;
            sync_q   <= sync_d;
            par_q    <= par_d;
            tx_pos_q <= tx_pos_d;
            tx_neg_q <= tx_neg_d;
            tx_en_q  <= tx_en_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign o_ready  = ready_q;
    assign o_tx_pos = tx_pos_q;
    assign o_tx_neg = tx_neg_q;
    assign o_tx_en  = tx_en_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_m1553_manchester_tx.sv
// tb/tb_m1553_manchester_tx.sv - directed bench for the 1553 Manchester transmitter
module tb_m1553_manchester_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [15:0] i_data;
    logic        i_sync;
    logic        o_ready;
    logic        o_tx_pos;
    logic        o_tx_neg;
    logic        o_tx_en;
    logic        o_done;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [15:0] data;
        logic        sync;
        logic        par;
        string       name;
    } vec_t;

    vec_t vecs [6];

    m1553_manchester_tx #(.CLKS_PER_HALF_BIT(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_sync_type (i_sync),
        .o_ready     (o_ready),
        .o_tx_pos    (o_tx_pos),
        .o_tx_neg    (o_tx_neg),
        .o_tx_en     (o_tx_en),
        .o_done      (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Expected o_tx_pos for half-bit idx (0..39) of a word
    function automatic logic exp_half(input logic [15:0] d, input logic s, input logic p, input int idx);
        logic b;
        if (idx < 6) return s ? (idx < 3) : (idx >= 3);
        if (idx < 38) begin
            b = d[15 - (idx - 6) / 2];
            return ((idx - 6) % 2 == 0) ? b : ~b;
        end
        return (idx == 38) ? p : ~p;
    endfunction

    // Called just after the acceptance edge; checks all 160 cycles of the word
    task automatic check_word(input logic [15:0] d, input logic s, input logic p, input string name);
        logic lv;
        logic [4:0] exp;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            lv  = exp_half(d, s, p, c / 4);
            exp = {lv, ~lv, 1'b1, c == 159, c == 159};
            chk(name, {27'd0, o_tx_pos, o_tx_neg, o_tx_en, o_done, o_ready}, {27'd0, exp});
        end
    endtask

    task automatic send(input logic [15:0] d, input logic s, input logic drop);
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = d;
        i_sync  = s;
        @(posedge clk);
        #1;
        if (drop) i_valid = 1'b0;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        chk(name, {27'd0, o_tx_pos, o_tx_neg, o_tx_en, o_done, o_ready}, 32'h1);
    endtask

    initial begin
        vecs[0] = '{16'h0000, 1'b1, 1'b1, "w0000_cmd"};
        vecs[1] = '{16'h0001, 1'b0, 1'b0, "w0001_dat"};
        vecs[2] = '{16'h8000, 1'b1, 1'b0, "w8000_cmd"};
        vecs[3] = '{16'hFFFE, 1'b0, 1'b0, "wfffe_dat"};
        vecs[4] = '{16'h5555, 1'b1, 1'b1, "w5555_cmd"};
        vecs[5] = '{16'hA5C3, 1'b0, 1'b1, "wa5c3_dat"};

        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = 16'h0;
        i_sync  = 1'b0;
        #12;
        chk("reset_state", {28'd0, o_tx_pos, o_tx_neg, o_tx_en, o_done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 1000; i++) check_idle("idle_1000");

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, vecs[i].sync, 1'b1);
            check_word(vecs[i].data, vecs[i].sync, vecs[i].par, vecs[i].name);
            check_idle({vecs[i].name, "_after"});
        end

        // Back-to-back words with i_valid held high
        send(16'hFFFF, 1'b1, 1'b0);
        i_data = 16'h5555;
        i_sync = 1'b0;
        check_word(16'hFFFF, 1'b1, 1'b1, "b2b_first");
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_data  = 16'h0;
        check_word(16'h5555, 1'b0, 1'b1, "b2b_second");
        check_idle("b2b_after");

        // Request and data change mid-word are ignored
        send(16'hA5C3, 1'b0, 1'b1);
        i_data = 16'h1111;
        fork
            check_word(16'hA5C3, 1'b0, 1'b1, "midword");
            begin
                repeat (50) @(negedge clk);
                i_valid = 1'b1;
                i_data  = 16'h0F0F;
                i_sync  = 1'b1;
                @(negedge clk);
                i_valid = 1'b0;
                i_data  = 16'hFFFF;
            end
        join
        for (int i = 0; i < 3; i++) check_idle("midword_after");

        // Asynchronous reset in half-bit 10
        send(16'h1234, 1'b1, 1'b1);
        repeat (41) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async", {28'd0, o_tx_pos, o_tx_neg, o_tx_en, o_done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release", {27'd0, o_tx_pos, o_tx_neg, o_tx_en, o_done, o_ready}, 32'h1);
        send(16'h8000, 1'b1, 1'b1);
        check_word(16'h8000, 1'b1, 1'b0, "post_reset");
        check_idle("post_reset_after");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
